regfile_wb_arbiter: RTL

Shares the single register-file write port between NUM_REQ writeback requesters, for example the ALU writeback and the load writeback. Each requester uses a valid/ready handshake. A round-robin arbiter selects one requester per cycle. The winning write is registered onto we_o/waddr_o/wdata_o, which drive the regfile's we_i/waddr_i/wdata_i directly. An optional scoreboard tracks registers with writes still outstanding, for use by hazard logic.

---
 rtl/regfile_wb_pkg.sv | 15 +
 rtl/regfile_wb_arbiter_if.sv | 29 ++
 rtl/regfile_wb_arbiter_rr_arbiter.sv | 27 ++
 rtl/regfile_wb_arbiter.sv | 104 ++++++++++
 4 files changed

// File: rtl/regfile_wb_pkg.sv
// Shared types and defaults for the regfile writeback arbiter.
package regfile_wb_pkg;

    localparam int RegNumLog2 = 5;
    localparam int RegBusW    = 32;
    localparam int RegNum     = 1 << RegNumLog2;
    localparam int MaxNumReq  = 4;
    localparam int IdxW       = $clog2(MaxNumReq);

    typedef struct packed {
        logic [RegNumLog2-1:0] addr;
        logic [RegBusW-1:0]    data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Packed valid/ready bundle for all writeback requesters.
interface regfile_wb_arbiter_if
    import regfile_wb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = RegNumLog2,
    parameter int DATA_W  = RegBusW
) ();

    logic [NUM_REQ-1:0]        req_valid_i;
    logic [NUM_REQ-1:0]        req_ready_o;
    logic [NUM_REQ*ADDR_W-1:0] req_waddr_i;
    logic [NUM_REQ*DATA_W-1:0] req_wdata_i;

    modport master (
        output req_valid_i,
        output req_waddr_i,
        output req_wdata_i,
        input  req_ready_o
    );

    modport slave (
        input  req_valid_i,
        input  req_waddr_i,
        input  req_wdata_i,
        output req_ready_o
    );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Combinational round-robin pick; the pointer register lives in the parent.
module rr_arbiter
    import regfile_wb_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]    req,
    input  logic [IdxW-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [IdxW-1:0] gnt_idx
);

    // Walk from the farthest slot back to ptr so the nearest requester wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            automatic int j = (int'(ptr) + k) % N;
            if (req[j]) begin
                gnt     = '0;
                gnt[j]  = 1'b1;
                gnt_idx = IdxW'(j);
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbitration of writeback requesters onto the regfile write port.
// Define WB_SCOREBOARD_EN to build the pending-write scoreboard.
module regfile_wb_arbiter
    import regfile_wb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = RegNumLog2,
    parameter int DATA_W  = RegBusW
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   hold_i,
    regfile_wb_arbiter_if.slave    req,
    output logic                   we_o,
    output logic [ADDR_W-1:0]      waddr_o,
    output logic [DATA_W-1:0]      wdata_o,
    output logic [IdxW-1:0]        grant_idx_o,
    input  logic                   alloc_valid_i,
    input  logic [ADDR_W-1:0]      alloc_addr_i,
    output logic [(1<<ADDR_W)-1:0] pending_o
);

    logic [IdxW-1:0]    r_ptr;
    logic               r_we;
    logic [ADDR_W-1:0]  r_waddr;
    logic [DATA_W-1:0]  r_wdata;
    logic [IdxW-1:0]    r_gidx;

    logic [NUM_REQ-1:0] w_gnt;
    logic [NUM_REQ-1:0] w_ready;
    logic [IdxW-1:0]    w_gnt_idx;
    logic [IdxW-1:0]    w_ptr_nxt;
    logic               w_xfer;
    logic [ADDR_W-1:0]  w_addr;
    logic [DATA_W-1:0]  w_data;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req     (req.req_valid_i),
        .ptr     (r_ptr),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    assign w_ready         = (rst_n && !hold_i) ? w_gnt : '0;
    assign req.req_ready_o = w_ready;
    assign w_xfer          = |w_ready;
    assign w_addr = req.req_waddr_i[int'(w_gnt_idx)*ADDR_W +: ADDR_W];
    assign w_data = req.req_wdata_i[int'(w_gnt_idx)*DATA_W +: DATA_W];
    assign w_ptr_nxt = (int'(w_gnt_idx) == NUM_REQ - 1) ? '0
                     : w_gnt_idx + IdxW'(1);

    // x0 writes are accepted but never presented to the regfile.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= '0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_gidx  <= '0;
        end else begin
            r_we <= w_xfer && (w_addr != '0);
            if (w_xfer) begin
                r_ptr  <= w_ptr_nxt;
                r_gidx <= w_gnt_idx;
                if (w_addr != '0) begin
                    r_waddr <= w_addr;
                    r_wdata <= w_data;
                end
            end
        end
    end

    assign we_o        = r_we;
    assign waddr_o     = r_waddr;
    assign wdata_o     = r_wdata;
    assign grant_idx_o = r_gidx;

`ifdef WB_SCOREBOARD_EN
    localparam int NReg = 1 << ADDR_W;

    logic [NReg-1:0] r_pending;
    logic [NReg-1:0] w_set;
    logic [NReg-1:0] w_clr;

    assign w_set = alloc_valid_i ? (NReg'(1) << alloc_addr_i) : '0;
    assign w_clr = r_we ? (NReg'(1) << r_waddr) : '0;

    // A same-edge alloc beats the commit: the new producer owns the register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= ((r_pending & ~w_clr) | w_set) & ~NReg'(1);
        end
    end

    assign pending_o = r_pending;
`else
    logic w_unused_alloc;
    assign w_unused_alloc = ^{alloc_valid_i, alloc_addr_i};
    assign pending_o      = '0;
`endif

endmodule
